// File: rtl/pipeline_pkg.sv
// Shared constants and types for the pipeline hazard controller.
//   FWD_REG/FWD_EX/FWD_MEM : operand-source encodings for fwd_a_sel/fwd_b_sel
//   hz_state_t             : controller state, also exported as busy_state
package pipeline_pkg;

    localparam int unsigned FWD_W = 2;
    localparam int unsigned CNT_W = 3;

    localparam logic [FWD_W-1:0] FWD_REG = 2'd0;
    localparam logic [FWD_W-1:0] FWD_EX  = 2'd1;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'd2;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } hz_state_t;

endpackage

// File: rtl/hazard_match.sv
// Compares both decode-stage sources against one in-flight writer.
// Register 0 is hardwired, so a zero destination never matches.
//   rs1_i/rs2_i, use_rs1_i/use_rs2_i : decode sources and their read enables
//   dst_i, wren_i                    : writer destination and write enable
//   match_rs1_o/match_rs2_o          : combinational match per source
module hazard_match #(
    parameter int unsigned REG_W = 5
) (
    input  logic [REG_W-1:0] rs1_i,
    input  logic [REG_W-1:0] rs2_i,
    input  logic             use_rs1_i,
    input  logic             use_rs2_i,
    input  logic [REG_W-1:0] dst_i,
    input  logic             wren_i,
    output logic             match_rs1_o,
    output logic             match_rs2_o
);

    logic dst_valid;

    assign dst_valid   = wren_i && (dst_i != '0);
    assign match_rs1_o = dst_valid && use_rs1_i && (rs1_i == dst_i);
    assign match_rs2_o = dst_valid && use_rs2_i && (rs2_i == dst_i);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/flow controller: stalls decode on RAW/load-use hazards, selects
// operand forwarding, flushes younger instructions after a taken jump and
// keeps saturating stall/flush cycle statistics.
// Build option: FORWARDING_EN enables EX/MEM forwarding (only loads in EX
// stall); without it every RAW on an in-flight writer stalls.
//   CLOCK_50, reset_n (sync, active low)
//   id_rs1/id_rs2/id_use_rs1/id_use_rs2 : decode sources
//   ex_write_reg/ex_reg_wren/ex_mem_to_reg, mem_write_reg/mem_reg_wren : writers
//   should_jump : taken jump resolved in mem_wb
//   stall_fd/bubble_ex/flush_fd/fwd_a_sel/fwd_b_sel : same-cycle controls
//   busy_state : registered controller state; stall_count/flush_count : stats
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned REG_W        = 5,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned STAT_W       = 16
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_W-1:0]  ex_write_reg,
    input  logic              ex_reg_wren,
    input  logic              ex_mem_to_reg,
    input  logic [REG_W-1:0]  mem_write_reg,
    input  logic              mem_reg_wren,
    input  logic              should_jump,
    output logic              stall_fd,
    output logic              bubble_ex,
    output logic              flush_fd,
    output logic [FWD_W-1:0]  fwd_a_sel,
    output logic [FWD_W-1:0]  fwd_b_sel,
    output logic [1:0]        busy_state,
    output logic [STAT_W-1:0] stall_count,
    output logic [STAT_W-1:0] flush_count
);

    localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam hz_state_t        JUMP_NEXT    = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

    hz_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STAT_W-1:0] stall_count_q, flush_count_q;

    logic ex_m1, ex_m2, mem_m1, mem_m2;
    logic hazard;
    logic [FWD_W-1:0] fwd_a, fwd_b;

    hazard_match #(.REG_W(REG_W)) u_match_ex (
        .rs1_i       (id_rs1),
        .rs2_i       (id_rs2),
        .use_rs1_i   (id_use_rs1),
        .use_rs2_i   (id_use_rs2),
        .dst_i       (ex_write_reg),
        .wren_i      (ex_reg_wren),
        .match_rs1_o (ex_m1),
        .match_rs2_o (ex_m2)
    );

    hazard_match #(.REG_W(REG_W)) u_match_mem (
        .rs1_i       (id_rs1),
        .rs2_i       (id_rs2),
        .use_rs1_i   (id_use_rs1),
        .use_rs2_i   (id_use_rs2),
        .dst_i       (mem_write_reg),
        .wren_i      (mem_reg_wren),
        .match_rs1_o (mem_m1),
        .match_rs2_o (mem_m2)
    );

`ifdef FORWARDING_EN
    // A load in EX has no result yet: stall one cycle, then forward from MEM.
    assign hazard = ex_mem_to_reg && (ex_m1 || ex_m2);
    assign fwd_a  = (ex_m1 && !ex_mem_to_reg) ? FWD_EX : (mem_m1 ? FWD_MEM : FWD_REG);
    assign fwd_b  = (ex_m2 && !ex_mem_to_reg) ? FWD_EX : (mem_m2 ? FWD_MEM : FWD_REG);
`else
    // No bypass network: wait until both writers have retired.
    logic unused_load;
    assign unused_load = ex_mem_to_reg;
    assign hazard      = ex_m1 || ex_m2 || mem_m1 || mem_m2;
    assign fwd_a       = FWD_REG;
    assign fwd_b       = FWD_REG;
`endif

    // Next state and Mealy controls; jump beats flush beats stall beats forwarding.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_fd  = 1'b0;
        bubble_ex = 1'b0;
        flush_fd  = 1'b0;
        fwd_a_sel = FWD_REG;
        fwd_b_sel = FWD_REG;

        if (should_jump) begin
            flush_fd  = 1'b1;
            bubble_ex = 1'b1;
            cnt_d     = FLUSH_RELOAD;
            state_d   = JUMP_NEXT;
        end else begin
            case (state_q)
                FLUSH: begin
                    flush_fd  = 1'b1;
                    bubble_ex = 1'b1;
                    cnt_d     = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    if (hazard) begin
                        stall_fd  = 1'b1;
                        bubble_ex = 1'b1;
                        state_d   = STALL;
                    end else begin
                        fwd_a_sel = fwd_a;
                        fwd_b_sel = fwd_b;
                        state_d   = RUN;
                    end
                end
            endcase
        end

        // Hold the pipeline inert while in reset.
        if (!reset_n) begin
            stall_fd  = 1'b0;
            bubble_ex = 1'b1;
            flush_fd  = 1'b1;
            fwd_a_sel = FWD_REG;
            fwd_b_sel = FWD_REG;
        end
    end

    // State, flush counter and saturating statistics.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q       <= RUN;
            cnt_q         <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (stall_fd && (stall_count_q != '1)) begin
                stall_count_q <= stall_count_q + STAT_W'(1);
            end
            if (flush_fd && (flush_count_q != '1)) begin
                flush_count_q <= flush_count_q + STAT_W'(1);
            end
        end
    end

    assign busy_state  = state_q;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl against a cycle-level model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned REG_W = 5;
    localparam int unsigned FC    = 2;
    localparam int unsigned SW    = 4;
    localparam int          SAT   = 15;

    logic             CLOCK_50 = 1'b0;
    logic             reset_n;
    logic [REG_W-1:0] id_rs1, id_rs2, ex_write_reg, mem_write_reg;
    logic             id_use_rs1, id_use_rs2, ex_reg_wren, ex_mem_to_reg, mem_reg_wren;
    logic             should_jump;
    logic             stall_fd, bubble_ex, flush_fd;
    logic [1:0]       fwd_a_sel, fwd_b_sel, busy_state;
    logic [SW-1:0]    stall_count, flush_count;
    logic [6:0]       dut_vec;

    int n_checks = 0;
    int n_pass   = 0;

    // model state
    int m_left = 0;
    int m_busy = 0;
    int m_stall_cnt = 0;
    int m_flush_cnt = 0;
    // model expectations for the current cycle
    logic       e_stall, e_bubble, e_flush;
    logic [1:0] e_fa, e_fb;
    logic [6:0] e_vec;
    int         e_next_left, e_next_busy;

    always #5 CLOCK_50 = ~CLOCK_50;

    pipeline_hazard_ctrl #(.REG_W(REG_W), .FLUSH_CYCLES(FC), .STAT_W(SW)) dut (
        .CLOCK_50      (CLOCK_50),
        .reset_n       (reset_n),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .ex_write_reg  (ex_write_reg),
        .ex_reg_wren   (ex_reg_wren),
        .ex_mem_to_reg (ex_mem_to_reg),
        .mem_write_reg (mem_write_reg),
        .mem_reg_wren  (mem_reg_wren),
        .should_jump   (should_jump),
        .stall_fd      (stall_fd),
        .bubble_ex     (bubble_ex),
        .flush_fd      (flush_fd),
        .fwd_a_sel     (fwd_a_sel),
        .fwd_b_sel     (fwd_b_sel),
        .busy_state    (busy_state),
        .stall_count   (stall_count),
        .flush_count   (flush_count)
    );

    assign dut_vec = {stall_fd, bubble_ex, flush_fd, fwd_a_sel, fwd_b_sel};

    // Expected controls for the current inputs, from the behavioural rules.
    task automatic model_eval();
        bit ex1, ex2, mem1, mem2, hz;
        ex1  = ex_reg_wren  && id_use_rs1 && (id_rs1 != 0) && (id_rs1 == ex_write_reg);
        ex2  = ex_reg_wren  && id_use_rs2 && (id_rs2 != 0) && (id_rs2 == ex_write_reg);
        mem1 = mem_reg_wren && id_use_rs1 && (id_rs1 != 0) && (id_rs1 == mem_write_reg);
        mem2 = mem_reg_wren && id_use_rs2 && (id_rs2 != 0) && (id_rs2 == mem_write_reg);
`ifdef FORWARDING_EN
        hz = ex_mem_to_reg && (ex1 || ex2);
`else
        hz = ex1 || ex2 || mem1 || mem2;
`endif
        e_stall = 0; e_bubble = 0; e_flush = 0; e_fa = 0; e_fb = 0;
        e_next_left = 0; e_next_busy = 0;
        if (!reset_n) begin
            e_bubble = 1; e_flush = 1;
        end else if (should_jump) begin
            e_bubble = 1; e_flush = 1;
            e_next_left = int'(FC) - 1;
            e_next_busy = (e_next_left > 0) ? 2 : 0;
        end else if (m_left > 0) begin
            e_bubble = 1; e_flush = 1;
            e_next_left = m_left - 1;
            e_next_busy = (e_next_left > 0) ? 2 : 0;
        end else if (hz) begin
            e_stall = 1; e_bubble = 1;
            e_next_busy = 1;
        end else begin
`ifdef FORWARDING_EN
            e_fa = (ex1 && !ex_mem_to_reg) ? 2'd1 : (mem1 ? 2'd2 : 2'd0);
            e_fb = (ex2 && !ex_mem_to_reg) ? 2'd1 : (mem2 ? 2'd2 : 2'd0);
`endif
        end
        e_vec = {e_stall, e_bubble, e_flush, e_fa, e_fb};
    endtask

    task automatic drive(input logic rn, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2,
                         input logic [4:0] exd, input logic exw, input logic exl,
                         input logic [4:0] memd, input logic memw, input logic j);
        @(negedge CLOCK_50);
        reset_n = rn; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        ex_write_reg = exd; ex_reg_wren = exw; ex_mem_to_reg = exl;
        mem_write_reg = memd; mem_reg_wren = memw; should_jump = j;
        #2;
        model_eval();
    endtask

    // Advance the model across the rising edge.
    task automatic commit();
        @(posedge CLOCK_50);
        if (!reset_n) begin
            m_left = 0; m_busy = 0; m_stall_cnt = 0; m_flush_cnt = 0;
        end else begin
            m_left = e_next_left;
            m_busy = e_next_busy;
            if (e_stall && m_stall_cnt < SAT) m_stall_cnt++;
            if (e_flush && m_flush_cnt < SAT) m_flush_cnt++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            commit();
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            commit();
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(0, 5, 5, 1, 1, 5, 1, 1, 5, 1, 1);
            n_checks++;
            if (dut_vec !== 7'b0110000) $display("FAIL reset_ctrl cyc%0d got=%b exp=%b", i, dut_vec, 7'b0110000);
            else n_pass++;
            commit();
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (busy_state !== 2'd0 || stall_count !== 0 || flush_count !== 0)
            $display("FAIL reset_state got busy=%0d sc=%0d fc=%0d exp 0/0/0", busy_state, stall_count, flush_count);
        else n_pass++;
        n_checks++;
        if (dut_vec !== e_vec) $display("FAIL reset_idle got=%b exp=%b", dut_vec, e_vec);
        else n_pass++;
        commit();
    endtask

    task automatic test_load_use();
        drive(1, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0);
        n_checks++;
        if (stall_fd !== 1'b1 || bubble_ex !== 1'b1 || dut_vec !== e_vec)
            $display("FAIL load_use_c1 got=%b exp=%b", dut_vec, e_vec);
        else n_pass++;
        commit();
        drive(1, 5, 0, 1, 0, 0, 0, 0, 5, 1, 0);
        n_checks++;
`ifdef FORWARDING_EN
        if (stall_fd !== 1'b0 || fwd_a_sel !== 2'd2 || dut_vec !== e_vec)
`else
        if (stall_fd !== 1'b1 || dut_vec !== e_vec)
`endif
            $display("FAIL load_use_c2 got=%b exp=%b", dut_vec, e_vec);
        else n_pass++;
        n_checks++;
        if (busy_state !== 2'(m_busy)) $display("FAIL load_use_busy got=%0d exp=%0d", busy_state, m_busy);
        else n_pass++;
        commit();
        drive(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (stall_fd !== 1'b0 || dut_vec !== e_vec) $display("FAIL load_use_c3 got=%b exp=%b", dut_vec, e_vec);
        else n_pass++;
        commit();
    endtask

    task automatic test_forward();
        drive(1, 0, 3, 0, 1, 3, 1, 0, 3, 1, 0);
        n_checks++;
`ifdef FORWARDING_EN
        if (fwd_b_sel !== 2'd1 || stall_fd !== 1'b0 || dut_vec !== e_vec)
`else
        if (stall_fd !== 1'b1 || dut_vec !== e_vec)
`endif
            $display("FAIL fwd_ex_over_mem got=%b exp=%b", dut_vec, e_vec);
        else n_pass++;
        commit();
        drive(1, 0, 0, 1, 1, 0, 1, 0, 0, 1, 0);
        n_checks++;
        if (dut_vec !== 7'b0000000) $display("FAIL fwd_r0 got=%b exp=%b", dut_vec, 7'b0000000);
        else n_pass++;
        commit();
        drive(1, 0, 7, 0, 1, 0, 0, 0, 7, 1, 0);
        n_checks++;
        if (dut_vec !== e_vec) $display("FAIL fwd_mem got=%b exp=%b", dut_vec, e_vec);
        else n_pass++;
        commit();
        drive(1, 7, 7, 0, 0, 7, 1, 0, 7, 1, 0);
        n_checks++;
        if (dut_vec !== 7'b0000000) $display("FAIL fwd_unused_src got=%b exp=%b", dut_vec, 7'b0000000);
        else n_pass++;
        commit();
        idle(2);
    endtask

    task automatic test_jump();
        int flushes;
        do_reset();
        flushes = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, (i == 0) ? 1'b1 : 1'b0);
            flushes += int'(flush_fd);
            n_checks++;
            if (dut_vec !== e_vec) $display("FAIL jump_cyc%0d got=%b exp=%b", i, dut_vec, e_vec);
            else n_pass++;
            commit();
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (flushes != int'(FC) || flush_count !== SW'(FC) || busy_state !== 2'd0)
            $display("FAIL jump_len got flushes=%0d fc=%0d busy=%0d exp %0d/%0d/0", flushes, flush_count, busy_state, FC, FC);
        else n_pass++;
        commit();
    endtask

    task automatic test_jump_in_stall();
        drive(1, 9, 0, 1, 0, 9, 1, 1, 0, 0, 0);
        n_checks++;
        if (stall_fd !== 1'b1) $display("FAIL jstall_pre got=%b exp=1", stall_fd);
        else n_pass++;
        commit();
        drive(1, 9, 0, 1, 0, 9, 1, 1, 0, 0, 1);
        n_checks++;
        if (stall_fd !== 1'b0 || flush_fd !== 1'b1 || bubble_ex !== 1'b1 || dut_vec !== e_vec)
            $display("FAIL jstall_abort got=%b exp=%b", dut_vec, e_vec);
        else n_pass++;
        commit();
        drive(1, 9, 0, 1, 0, 9, 1, 1, 0, 0, 0);
        n_checks++;
        if (busy_state !== 2'(m_busy) || flush_fd !== 1'b1 || dut_vec !== e_vec)
            $display("FAIL jstall_flush got busy=%0d vec=%b exp busy=%0d vec=%b", busy_state, dut_vec, m_busy, e_vec);
        else n_pass++;
        commit();
        idle(3);
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1, 4, 4, 1, 1, 4, 1, 1, 4, 1, 0);
            n_checks++;
            if (dut_vec !== e_vec) $display("FAIL sat_cyc%0d got=%b exp=%b", i, dut_vec, e_vec);
            else n_pass++;
            commit();
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (stall_count !== 4'd15 || m_stall_cnt != SAT)
            $display("FAIL sat_count got=%0d exp=%0d", stall_count, SAT);
        else n_pass++;
        commit();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 49) != 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) == 0));
            n_checks++;
            if (dut_vec !== e_vec) $display("FAIL rnd_ctrl cyc%0d got=%b exp=%b", i, dut_vec, e_vec);
            else n_pass++;
            if (reset_n) begin
                n_checks++;
                if (busy_state !== 2'(m_busy) || stall_count !== SW'(m_stall_cnt) || flush_count !== SW'(m_flush_cnt))
                    $display("FAIL rnd_state cyc%0d got busy=%0d sc=%0d fc=%0d exp %0d/%0d/%0d",
                             i, busy_state, stall_count, flush_count, m_busy, m_stall_cnt, m_flush_cnt);
                else n_pass++;
            end
            commit();
        end
    endtask

    initial begin
        reset_n = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_write_reg = 0; ex_reg_wren = 0; ex_mem_to_reg = 0;
        mem_write_reg = 0; mem_reg_wren = 0; should_jump = 0;
        test_reset();
        test_load_use();
        test_forward();
        test_jump();
        test_jump_in_stall();
        test_saturate();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
